// File: rtl/generic_rom_reader.sv
// Read-side initiator for a registered-output ROM: walks an address range and
// streams the words out through a credit-controlled FIFO with a last marker.
module generic_rom_reader #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 10,
   parameter int unsigned ROM_LATENCY   = 2,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
   input  logic [ADDRESS_WIDTH:0]   i_count,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [ADDRESS_WIDTH-1:0] o_rom_address,
   input  logic [DATA_WIDTH-1:0]    i_rom_read_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [DATA_WIDTH-1:0]    o_data,
   output logic                     o_last
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;
   localparam logic [ADDRESS_WIDTH:0] ONE_CNT = (ADDRESS_WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                   state_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [ADDRESS_WIDTH-1:0] rom_addr_q;
   logic [ADDRESS_WIDTH:0]   remain_q;
   logic                     busy_q;
   logic                     done_q;

   // One stage beyond ROM_LATENCY: the token also covers our own address register.
   logic [ROM_LATENCY:0]     tok_v_q;
   logic [ROM_LATENCY:0]     tok_l_q;

   logic [DATA_WIDTH-1:0]    mem_data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]    mem_last_q;
   logic [PW-1:0]            wr_ptr_q;
   logic [PW-1:0]            rd_ptr_q;
   logic [CW-1:0]            fifo_cnt_q;
   logic [CW-1:0]            fifo_cnt_d;

   logic [CW-1:0]            inflight;
   logic [CW-1:0]            credit_used;
   logic                     fifo_valid;
   logic                     pop;
   logic                     wr;
   logic                     issue;
   logic                     last_issue;
   logic                     accept;

   assign fifo_valid = (fifo_cnt_q != '0);
   assign pop        = fifo_valid & i_ready;
   assign wr         = tok_v_q[ROM_LATENCY];
   assign accept     = i_start & ((state_q == S_IDLE) | (state_q == S_DONE));

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i <= ROM_LATENCY; i++) begin
         inflight = inflight + CW'(tok_v_q[i]);
      end
   end

   // The slot freed by a same-cycle pop is reusable, so FIFO_DEPTH = latency + 2
   // still sustains one word per cycle.
   assign credit_used = fifo_cnt_q + inflight - CW'(pop);
   assign issue       = (state_q == S_ISSUE) && (remain_q != '0) &&
                        (credit_used < CW'(FIFO_DEPTH));
   assign last_issue  = issue && (remain_q == ONE_CNT);
   assign fifo_cnt_d  = fifo_cnt_q + CW'(wr) - CW'(pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rom_addr_q <= '0;
         remain_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (issue) begin
            rom_addr_q <= addr_q;
            addr_q     <= addr_q + ADDRESS_WIDTH'(1);
            remain_q   <= remain_q - ONE_CNT;
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  addr_q   <= i_base_addr;
                  remain_q <= i_count;
                  if (i_count == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_ISSUE;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (last_issue) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && mem_last_q[rd_ptr_q]) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tok_v_q <= '0;
         tok_l_q <= '0;
      end else begin
         tok_v_q <= {tok_v_q[ROM_LATENCY-1:0], issue};
         tok_l_q <= {tok_l_q[ROM_LATENCY-1:0], last_issue};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= '0;
         end
         mem_last_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (wr) begin
            mem_data_q[wr_ptr_q] <= i_rom_read_data;
            mem_last_q[wr_ptr_q] <= tok_l_q[ROM_LATENCY];
            wr_ptr_q             <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_rom_address = rom_addr_q;
   assign o_valid       = fifo_valid;
   assign o_data        = mem_data_q[rd_ptr_q];
   assign o_last        = fifo_valid & mem_last_q[rd_ptr_q];

endmodule
